spine_router_xbar: RTL and testbench

- Parametrised next-generation spine router: NUM_LEAF leaf ports plus NUM_GROUP inter-group ports, all carried on packed buses.
- Each port has an ingress FIFO and a registered egress stage with valid/ready backpressure.
- Every output has its own round-robin arbiter; destinations that do not decode are dropped and counted.
- Sits between the leaf routers of one group and the spine routers of the other groups.

---
 rtl/spine_router_pkg.sv | 32 +++
 rtl/router_fifo.sv | 48 ++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/spine_router_xbar.sv | 125 ++++++++++++
 tb/tb_spine_router_xbar.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spine_router_pkg.sv
// Shared field layout and route decode for the spine router crossbar.
package spine_router_pkg;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_GID_W  = 4;
    localparam int DEF_LID_W  = 4;

    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Destination group sits at the top of the flit, destination leaf right below it
    function automatic int gid_lsb(input int dwidth, input int gid_w);
        return dwidth - gid_w;
    endfunction

    function automatic int lid_lsb(input int dwidth, input int gid_w, input int lid_w);
        return dwidth - gid_w - lid_w;
    endfunction

    // Returns the output port index, or -1 when the destination does not decode.
    // Group ports skip our own group number, so groups above GROUP_ID shift down by one.
    function automatic int route_decode(input int dg, input int dl, input int group_id,
                                        input int num_leaf, input int num_group);
        if (dg == group_id)
            return (dl < num_leaf) ? dl : -1;
        if (dg <= num_group)
            return num_leaf + ((dg < group_id) ? dg : dg - 1);
        return -1;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Ingress FIFO: synchronous, async reset, registered full/empty flags.
module router_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTW = AW + 1;

    logic [W-1:0]   mem [DEPTH];
    logic [PTW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic           push_ok, pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign wr_nxt  = wr_ptr + PTW'(push_ok);
    assign rd_nxt  = rd_ptr + PTW'(pop_ok);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            empty  <= (wr_nxt == rd_nxt);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after its pointer.
module rr_arbiter
    import spine_router_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = port_idx_w(N);

    logic [PW-1:0] ptr, gidx;
    logic          found;

    // First pass covers indices >= ptr, second pass wraps to the low indices
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i] && (PW'(i) >= ptr)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gidx   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gidx   = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (found)
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end

endmodule

// File: rtl/spine_router_xbar.sv
// Spine router crossbar: per-port ingress FIFO, per-output RR arbiter and egress register.
module spine_router_xbar
    import spine_router_pkg::*;
#(
    parameter int GROUP_ID   = 7,
    parameter int NUM_LEAF   = 4,
    parameter int NUM_GROUP  = 7,
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int GID_W      = DEF_GID_W,
    parameter int LID_W      = DEF_LID_W,
    parameter int FIFO_DEPTH = 8,
    localparam int NUM_PORTS = NUM_LEAF + NUM_GROUP
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS*DWIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS-1:0]          drop_pulse,
    output logic [15:0]                   drop_count
);
    localparam int PW      = port_idx_w(NUM_PORTS);
    localparam int GID_LSB = gid_lsb(DWIDTH, GID_W);
    localparam int LID_LSB = lid_lsb(DWIDTH, GID_W, LID_W);

    logic [NUM_PORTS-1:0][DWIDTH-1:0]    head, egr_data;
    logic [NUM_PORTS-1:0]                fifo_full, fifo_empty, head_vld;
    logic [NUM_PORTS-1:0]                route_ok, drop, pop, load_en;
    logic [NUM_PORTS-1:0][PW-1:0]        route;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req, gnt;   // [output][input]
    logic [16:0]                         ndrop, dc_sum;
    int                                  dec;

    assign in_ready   = ~fifo_full;
    assign head_vld   = ~fifo_empty;
    assign drop       = head_vld & ~route_ok;
    assign drop_pulse = drop;
    assign load_en    = ~out_valid | out_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        router_fifo #(.W(DWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .reset_n(reset_n),
            .push   (in_valid[p] & ~fifo_full[p]),
            .din    (in_data[p*DWIDTH +: DWIDTH]),
            .pop    (pop[p]),
            .dout   (head[p]),
            .full   (fifo_full[p]),
            .empty  (fifo_empty[p])
        );

        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk    (clk),
            .reset_n(reset_n),
            .req    (req[p]),
            .en     (load_en[p]),
            .gnt    (gnt[p])
        );
    end

    always_comb begin
        route_ok = '0;
        route    = '0;
        dec      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dec = route_decode(int'(head[i][GID_LSB +: GID_W]), int'(head[i][LID_LSB +: LID_W]),
                               GROUP_ID, NUM_LEAF, NUM_GROUP);
            if (dec >= 0) begin
                route_ok[i] = 1'b1;
                route[i]    = PW'(dec);
            end
        end
    end

    always_comb begin
        req = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            for (int i = 0; i < NUM_PORTS; i++)
                req[o][i] = head_vld[i] & route_ok[i] & (route[i] == PW'(o));
    end

    // Each input requests a single output, so OR-ing the grants gives at most one pop per input
    always_comb begin
        pop      = drop;
        egr_data = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            pop = pop | gnt[o];
            for (int i = 0; i < NUM_PORTS; i++)
                egr_data[o] = egr_data[o] | (head[i] & {DWIDTH{gnt[o][i]}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (load_en[o]) begin
                    out_valid[o] <= |gnt[o];
                    if (|gnt[o])
                        out_data[o*DWIDTH +: DWIDTH] <= egr_data[o];
                end
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            ndrop = ndrop + 17'(drop[i]);
        dc_sum = {1'b0, drop_count} + ndrop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_count <= '0;
        else
            drop_count <= dc_sum[16] ? 16'hFFFF : dc_sum[15:0];
    end

endmodule

// File: tb/tb_spine_router_xbar.sv
// Directed bench for spine_router_xbar with a per-output scoreboard on egress handshakes.
module tb_spine_router_xbar;
    localparam int NP = 11;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP*DW-1:0]  in_data, out_data;
    logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready, drop_pulse;
    logic [15:0]       drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sb [NP][$];
    int pop_cnt [NP];
    int first_cyc [NP];
    int last_cyc [NP];
    logic [31:0] mon_exp;

    spine_router_xbar #(
        .GROUP_ID(7), .NUM_LEAF(4), .NUM_GROUP(7), .DWIDTH(16),
        .GID_W(4), .LID_W(4), .FIFO_DEPTH(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Handshakes are sampled mid-cycle; valid&ready here completes at the next posedge
    always @(negedge clk) begin
        if (reset_n) begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    if (sb[o].size() > 0) mon_exp = 32'(sb[o].pop_front());
                    else                  mon_exp = 32'hDEAD_0000 | 32'(o);
                    chk($sformatf("egress_port%0d", o), 32'(out_data[o*DW +: DW]), mon_exp);
                    if (pop_cnt[o] == 0) first_cyc[o] = cyc;
                    last_cyc[o] = cyc;
                    pop_cnt[o]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [15:0] d);
        in_valid[p]          = 1'b1;
        in_data[p*DW +: DW]  = d;
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic clr_stats();
        for (int o = 0; o < NP; o++) begin
            pop_cnt[o] = 0;
            sb[o].delete();
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        idle();
        out_ready = '1;
        clr_stats();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int pulses, sent, pc0;
        logic [NP-1:0] other_pulse, any_valid;
        logic [15:0] snap;

        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        clr_stats();
        #2;
        chk("reset_in_ready",   32'(in_ready),   32'h7FF);
        chk("reset_out_valid",  32'(out_valid),  32'h0);
        chk("reset_out_data",   32'(|out_data),  32'h0);
        chk("reset_drop_count", 32'(drop_count), 32'h0);
        chk("reset_drop_pulse", 32'(drop_pulse), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Leaf route with 2-edge latency
        send(0, 16'h7200); sb[2].push_back(16'h7200);
        tick(); idle();
        chk("leaf_edge1_no_valid", 32'(out_valid), 32'h0);
        tick();
        chk("leaf_edge2_valid", 32'(out_valid), 32'h4);
        chk("leaf_data", 32'(out_data[2*DW +: DW]), 32'h7200);
        repeat (2) tick();

        // Group routes: group 3 -> port 7, group 6 -> port 10
        send(1, 16'h3000); sb[7].push_back(16'h3000);
        send(5, 16'h6ABC); sb[10].push_back(16'h6ABC);
        tick(); idle();
        tick();
        chk("group_valid", 32'(out_valid), 32'h480);
        chk("group_data7",  32'(out_data[7*DW +: DW]),  32'h3000);
        chk("group_data10", 32'(out_data[10*DW +: DW]), 32'h6ABC);
        repeat (2) tick();

        // Drops: bad leaf, then bad group
        do_reset();
        pulses = 0; other_pulse = '0; any_valid = '0;
        send(3, 16'h7500); tick();
        pulses += int'(drop_pulse[3]); other_pulse |= drop_pulse & ~11'h8; any_valid |= out_valid;
        send(3, 16'h9000); tick(); idle();
        pulses += int'(drop_pulse[3]); other_pulse |= drop_pulse & ~11'h8; any_valid |= out_valid;
        repeat (4) begin
            tick();
            pulses += int'(drop_pulse[3]); other_pulse |= drop_pulse & ~11'h8; any_valid |= out_valid;
        end
        chk("drop_pulses",      32'(pulses),      32'd2);
        chk("drop_other_ports", 32'(other_pulse), 32'h0);
        chk("drop_no_egress",   32'(any_valid),   32'h0);
        chk("drop_count_2",     32'(drop_count),  32'd2);

        // Saturation: every port streams undecodable flits
        for (int p = 0; p < NP; p++) send(p, 16'h9000);
        for (int k = 0; k < 8000 && drop_count != 16'hFFFF; k++) tick();
        chk("sat_reached", 32'(drop_count), 32'hFFFF);
        repeat (20) tick();
        chk("sat_hold_busy", 32'(drop_count), 32'hFFFF);
        idle();
        repeat (12) tick();
        chk("sat_hold_idle", 32'(drop_count), 32'hFFFF);

        // Round-robin contention on leaf 2 from ports 0,1,5
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(0, 16'h7200 | 16'(k)); sb[2].push_back(16'h7200 | k);
            send(1, 16'h7210 | 16'(k)); sb[2].push_back(16'h7210 | k);
            send(5, 16'h7250 | 16'(k)); sb[2].push_back(16'h7250 | k);
            tick();
        end
        idle();
        for (int k = 0; k < 40 && pop_cnt[2] < 12; k++) tick();
        chk("rr_count",       32'(pop_cnt[2]),                 32'd12);
        chk("rr_consecutive", 32'(last_cyc[2] - first_cyc[2]), 32'd11);
        chk("rr_sb_empty",    32'(sb[2].size()),               32'd0);

        // Backpressure on leaf 2 while port 0 streams 10 flits
        out_ready[2] = 1'b0;
        pc0  = pop_cnt[2];
        sent = 0;
        snap = '0;
        for (int k = 0; k < 14; k++) begin
            if (in_ready[0] && sent < 10) begin
                send(0, 16'h7280 + 16'(sent)); sb[2].push_back(16'h7280 + sent);
                sent++;
            end else idle();
            tick();
            if (k == 4) snap = out_data[2*DW +: DW];
        end
        idle();
        chk("bp_accepted",     32'(sent),                  32'd9);
        chk("bp_in_ready_low", 32'(in_ready[0]),           32'h0);
        chk("bp_valid_held",   32'(out_valid[2]),          32'h1);
        chk("bp_data_held",    32'(out_data[2*DW +: DW]),  32'(snap));
        chk("bp_data_first",   32'(out_data[2*DW +: DW]),  32'h7280);
        out_ready[2] = 1'b1;
        for (int k = 0; k < 40 && !(sent == 10 && sb[2].size() == 0); k++) begin
            if (in_ready[0] && sent < 10) begin
                send(0, 16'h7280 + 16'(sent)); sb[2].push_back(16'h7280 + sent);
                sent++;
            end else idle();
            tick();
        end
        idle();
        repeat (2) tick();
        chk("bp_all_sent",    32'(sent),               32'd10);
        chk("bp_all_arrived", 32'(pop_cnt[2] - pc0),   32'd10);
        chk("bp_sb_empty",    32'(sb[2].size()),       32'd0);

        // Async reset in the middle of traffic
        out_ready[2] = 1'b0;
        send(0, 16'h72F0);
        send(3, 16'h9000);
        repeat (3) tick();
        #1 reset_n = 1'b0;
        #1;
        chk("areset_out_valid",  32'(out_valid),  32'h0);
        chk("areset_drop_count", 32'(drop_count), 32'h0);
        chk("areset_in_ready",   32'(in_ready),   32'h7FF);
        chk("areset_drop_pulse", 32'(drop_pulse), 32'h0);
        idle();
        out_ready = '1;
        clr_stats();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_idle", 32'(out_valid), 32'h0);
        send(4, 16'h7100); sb[1].push_back(16'h7100);
        tick(); idle();
        chk("post_reset_edge1", 32'(out_valid), 32'h0);
        tick();
        chk("post_reset_valid", 32'(out_valid), 32'h2);
        chk("post_reset_data",  32'(out_data[1*DW +: DW]), 32'h7100);
        repeat (3) tick();
        for (int o = 0; o < NP; o++)
            if (sb[o].size() != 0) chk($sformatf("sb_leftover_port%0d", o), 32'(sb[o].size()), 32'd0);
        chk("final_drop_count", 32'(drop_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
